// File: rtl/mem_bus_router.sv
// Single-initiator address decoder/router onto N_TARGETS valid/ready targets.
// Unmapped or hung accesses complete with an error response so the core never stalls forever.
module mem_bus_router #(
   parameter int N_TARGETS      = 3,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter logic [N_TARGETS*ADDR_WIDTH-1:0] BASE_ADDRS = '0,
   parameter logic [N_TARGETS*ADDR_WIDTH-1:0] ADDR_MASKS = '0,
   parameter int TIMEOUT_CYCLES = 256,
   parameter logic [DATA_WIDTH-1:0] ERR_RDATA = DATA_WIDTH'(32'hDEADBEEF),
   localparam int WE_WIDTH      = DATA_WIDTH / 8
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            s_valid_i,
   output logic                            s_ready_o,
   input  logic [ADDR_WIDTH-1:0]           s_addr_i,
   input  logic [DATA_WIDTH-1:0]           s_wdata_i,
   input  logic [WE_WIDTH-1:0]             s_we_i,
   output logic [DATA_WIDTH-1:0]           s_rdata_o,
   output logic [N_TARGETS-1:0]            m_valid_o,
   input  logic [N_TARGETS-1:0]            m_ready_i,
   output logic [ADDR_WIDTH-1:0]           m_addr_o,
   output logic [DATA_WIDTH-1:0]           m_wdata_o,
   output logic [WE_WIDTH-1:0]             m_we_o,
   input  logic [N_TARGETS*DATA_WIDTH-1:0] m_rdata_i,
   output logic                            err_o,
   output logic                            err_cause_o,
   output logic [ADDR_WIDTH-1:0]           err_addr_o
);

   localparam int SW = (N_TARGETS > 1) ? $clog2(N_TARGETS) : 1;
   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_ERR  = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [SW-1:0]         sel_q, sel_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  err_cause_q, err_cause_d;
   logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

   logic                  hit;
   logic [SW-1:0]         hit_idx;
   logic                  sel_ready;
   logic [DATA_WIDTH-1:0] sel_rdata;

   // Walk downwards so the lowest-index match is the one left standing on overlap.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int k = N_TARGETS - 1; k >= 0; k--) begin
         if ((s_addr_i & ADDR_MASKS[k*ADDR_WIDTH +: ADDR_WIDTH]) == BASE_ADDRS[k*ADDR_WIDTH +: ADDR_WIDTH]) begin
            hit     = 1'b1;
            hit_idx = SW'(k);
         end
      end
   end

   always_comb begin
      sel_ready = 1'b0;
      sel_rdata = '0;
      for (int k = 0; k < N_TARGETS; k++) begin
         if (sel_q == SW'(k)) begin
            sel_ready = m_ready_i[k];
            sel_rdata = m_rdata_i[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      cnt_d       = cnt_q;
      err_cause_d = err_cause_q;
      err_addr_d  = err_addr_q;
      s_ready_o   = 1'b0;
      s_rdata_o   = '0;
      err_o       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (s_valid_i) begin
               if (hit) begin
                  sel_d   = hit_idx;
                  cnt_d   = '0;
                  state_d = S_BUSY;
               end else begin
                  err_cause_d = 1'b0;
                  err_addr_d  = s_addr_i;
                  state_d     = S_ERR;
               end
            end
         end
         S_BUSY: begin
            // An initiator that withdraws its request gets neither data nor an error.
            if (!s_valid_i) begin
               state_d = S_IDLE;
            end else if (sel_ready) begin
               s_ready_o = 1'b1;
               s_rdata_o = sel_rdata;
               state_d   = S_IDLE;
            end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
               err_cause_d = 1'b1;
               err_addr_d  = s_addr_i;
               state_d     = S_ERR;
            end else if (TIMEOUT_CYCLES != 0) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_ERR: begin
            s_ready_o = 1'b1;
            s_rdata_o = ERR_RDATA;
            err_o     = 1'b1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      m_valid_o = '0;
      for (int k = 0; k < N_TARGETS; k++) begin
         m_valid_o[k] = (state_q == S_BUSY) && (sel_q == SW'(k));
      end
      m_we_o = (state_q == S_BUSY) ? s_we_i : '0;
   end

   assign m_addr_o    = s_addr_i;
   assign m_wdata_o   = s_wdata_i;
   assign err_cause_o = err_cause_q;
   assign err_addr_o  = err_addr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         sel_q       <= '0;
         cnt_q       <= '0;
         err_cause_q <= 1'b0;
         err_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         cnt_q       <= cnt_d;
         err_cause_q <= err_cause_d;
         err_addr_q  <= err_addr_d;
      end
   end

endmodule
